// File: rtl/fml_wrdma_if.sv
// Source word stream plus FML 4x32 write port of the write DMA.
// master = DMA side, slave = stream source / memory controller side.
interface fml_wrdma_if #(
  parameter int sdram_depth = 26
);
  logic                   s_valid;
  logic [31:0]            s_data;
  logic                   s_ready;
  logic [sdram_depth-1:0] fml_adr;
  logic                   fml_stb;
  logic                   fml_we;
  logic [3:0]             fml_sel;
  logic [31:0]            fml_do;
  logic                   fml_ack;

  modport master (
    input  s_valid, s_data, fml_ack,
    output s_ready, fml_adr, fml_stb, fml_we, fml_sel, fml_do
  );

  modport slave (
    output s_valid, s_data, fml_ack,
    input  s_ready, fml_adr, fml_stb, fml_we, fml_sel, fml_do
  );
endinterface

// File: rtl/fml_wrdma.sv
// Stream-to-FML write DMA: words fill a two-half ping-pong buffer while the
// drain FSM writes completed halves out as 4-beat FML bursts.
module fml_wrdma #(
  parameter int sdram_depth = 26
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   start,
  input  logic [sdram_depth-1:0] base_adr,
  input  logic [15:0]            nbursts,
  output logic                   busy,
  output logic                   done,
  fml_wrdma_if.master            bus
);

  localparam int DATA_W = 32;
  localparam logic [sdram_depth-1:0] ADR_MASK    = {{(sdram_depth-4){1'b1}}, 4'h0};
  localparam logic [sdram_depth-1:0] BURST_BYTES = {{(sdram_depth-5){1'b0}}, 5'h10};

  typedef enum logic [1:0] {D_IDLE, D_REQ, D_BEAT} dstate_t;

  dstate_t                r_dstate;
  logic                   r_busy;
  logic                   r_done;
  logic [sdram_depth-1:0] r_adr;
  logic [15:0]            r_nbursts;
  logic [15:0]            r_bursts_done;
  logic [17:0]            r_words_acc;
  logic [1:0]             r_full;
  logic                   r_fill_half;
  logic [1:0]             r_fill_idx;
  logic                   r_drain_half;
  logic [1:0]             r_beat;
  logic                   r_stb;
  logic                   r_we;
  logic [3:0]             r_sel;
  logic [sdram_depth-1:0] r_fml_adr;
  logic [DATA_W-1:0]      r_mem [2][4];

  logic                   w_start_ok;
  logic                   w_s_ready;
  logic                   w_push;
  logic                   w_fill_last;
  logic [1:0]             w_set;
  logic [1:0]             w_free;
  logic [1:0]             w_full_eff;
  logic                   w_ack;
  logic                   w_last_beat;
  logic                   w_last_burst;
  logic [DATA_W-1:0]      w_do;

  assign w_start_ok   = start & ~r_busy;
  assign w_s_ready    = r_busy & ~r_full[r_fill_half] & (r_words_acc < {r_nbursts, 2'b00});
  assign w_push       = w_s_ready & bus.s_valid;
  assign w_fill_last  = w_push & (r_fill_idx == 2'd3);
  assign w_set        = {2{w_fill_last}} & (r_fill_half ? 2'b10 : 2'b01);
  assign w_last_beat  = (r_dstate == D_BEAT) & (r_beat == 2'd3);
  assign w_free       = {2{w_last_beat}} & (r_drain_half ? 2'b10 : 2'b01);
  // A half completing this cycle counts as full so the drain can start at once.
  assign w_full_eff   = r_full | w_set;
  assign w_ack        = r_stb & bus.fml_ack;
  assign w_last_burst = ((r_bursts_done + 16'd1) == r_nbursts);

  // Buffer storage: data only, validity lives in r_full.
  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_fill_half][r_fill_idx] <= bus.s_data;
  end

  always_comb begin
    w_do = '0;
    if ((r_dstate == D_REQ) && w_ack) w_do = r_mem[r_drain_half][0];
    else if (r_dstate == D_BEAT)      w_do = r_mem[r_drain_half][r_beat];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_dstate      <= D_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_adr         <= '0;
      r_nbursts     <= '0;
      r_bursts_done <= '0;
      r_words_acc   <= '0;
      r_full        <= '0;
      r_fill_half   <= 1'b0;
      r_fill_idx    <= '0;
      r_drain_half  <= 1'b0;
      r_beat        <= '0;
      r_stb         <= 1'b0;
      r_we          <= 1'b0;
      r_sel         <= '0;
      r_fml_adr     <= '0;
    end else begin
      r_done <= 1'b0;

      if (w_start_ok) begin
        if (nbursts == 16'd0) begin
          r_done <= 1'b1;
        end else begin
          r_busy        <= 1'b1;
          r_adr         <= base_adr & ADR_MASK;
          r_nbursts     <= nbursts;
          r_bursts_done <= '0;
          r_words_acc   <= '0;
          r_fill_half   <= 1'b0;
          r_fill_idx    <= '0;
          r_drain_half  <= 1'b0;
        end
      end

      if (w_push) begin
        r_words_acc <= r_words_acc + 18'd1;
        r_fill_idx  <= r_fill_idx + 2'd1;
        if (w_fill_last) r_fill_half <= ~r_fill_half;
      end

      // Fill of one half and release of the other may coincide.
      r_full <= (r_full & ~w_free) | w_set;

      case (r_dstate)
        D_IDLE: begin
          if (r_busy && w_full_eff[r_drain_half]) begin
            r_dstate  <= D_REQ;
            r_stb     <= 1'b1;
            r_we      <= 1'b1;
            r_sel     <= 4'hF;
            r_fml_adr <= r_adr;
          end
        end
        D_REQ: begin
          if (w_ack) begin
            r_dstate <= D_BEAT;
            r_beat   <= 2'd1;
            r_stb    <= 1'b0;
            r_we     <= 1'b0;
            r_sel    <= 4'h0;
          end
        end
        D_BEAT: begin
          if (r_beat == 2'd3) begin
            r_drain_half  <= ~r_drain_half;
            r_adr         <= r_adr + BURST_BYTES;
            r_bursts_done <= r_bursts_done + 16'd1;
            if (w_last_burst) begin
              r_dstate <= D_IDLE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else if (w_full_eff[~r_drain_half]) begin
              r_dstate  <= D_REQ;
              r_stb     <= 1'b1;
              r_we      <= 1'b1;
              r_sel     <= 4'hF;
              r_fml_adr <= r_adr + BURST_BYTES;
            end else begin
              r_dstate <= D_IDLE;
            end
          end else begin
            r_beat <= r_beat + 2'd1;
          end
        end
        default: r_dstate <= D_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign bus.s_ready = w_s_ready;
  assign bus.fml_stb = r_stb;
  assign bus.fml_we  = r_we;
  assign bus.fml_sel = r_sel;
  assign bus.fml_adr = r_fml_adr;
  assign bus.fml_do  = w_do;

endmodule

// File: tb/tb_fml_wrdma.sv
// Bench for fml_wrdma: table of transfers, directed reset-mid-burst, and random
// transfers, all checked cycle by cycle against a word/burst-level model.
module tb_fml_wrdma;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        start;
  logic [25:0] base_adr;
  logic [15:0] nbursts;
  logic        busy;
  logic        done;

  fml_wrdma_if #(.sdram_depth(26)) bus ();

  fml_wrdma #(.sdram_depth(26)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .base_adr (base_adr),
    .nbursts  (nbursts),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  typedef struct {
    logic [25:0] base;
    int          n;
    int          ack_delay;
    bit          ack_rand;
    int          valid_pct;
    bit          spur;
    bit          fixed;
    bit          busy_start;
    logic [25:0] exp_first;
    logic [25:0] exp_last;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // stimulus knobs
  logic [31:0] src_q[$];
  int valid_pct = 100;
  int ack_delay = 0;
  bit ack_rand = 0;
  bit spur = 0;
  int stb_age = 0;
  int cur_delay = 0;

  // model state
  logic [31:0] m_words[$];
  bit          m_busy = 0;
  bit          m_done_due = 0;
  int          m_n = 0;
  logic [25:0] m_base = '0;
  int          m_acc = 0;
  int          m_freed = 0;
  int          m_burst = 0;
  int          m_beat = 0;
  int          m_done_cnt = 0;
  int          m_bursts_seen = 0;
  logic [25:0] m_first_adr = '0;
  logic [25:0] m_last_adr = '0;
  int          m_hs_cyc = 0;
  int          m_stb_rise_cyc = 0;
  bit          m_stb_prev = 0;
  int          m_max_buf = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // stream source
  always @(posedge sys_clk) begin
    #1;
    if (src_q.size() > 0 && $urandom_range(99) < valid_pct) begin
      bus.s_valid = 1'b1;
      bus.s_data  = src_q[0];
    end else begin
      bus.s_valid = 1'b0;
      bus.s_data  = $urandom;
    end
  end

  // FML responder
  always @(posedge sys_clk) begin
    #1;
    if (bus.fml_stb) begin
      if (stb_age == 0) cur_delay = ack_rand ? int'($urandom_range(0, 5)) : ack_delay;
      bus.fml_ack = (stb_age >= cur_delay);
      stb_age++;
    end else begin
      stb_age = 0;
      bus.fml_ack = spur && ($urandom_range(3) == 0);
    end
  end

  // Model: busy/done/ready derived from counts of accepted and freed words.
  always @(negedge sys_clk) begin : mon
    bit nb_busy;
    bit nb_done;
    bit exp_rdy;
    int idx;
    logic [25:0] ea;
    if (!sys_rst_n) begin
      chk("rst_ctl", {busy, done, bus.s_ready, bus.fml_stb, bus.fml_we, bus.fml_sel}, 0);
      chk("rst_adr_do", {bus.fml_adr, bus.fml_do}, 0);
      m_busy = 0; m_done_due = 0; m_beat = 0; m_acc = 0; m_freed = 0; m_burst = 0;
      m_stb_prev = 0;
    end else begin
      nb_busy = m_busy;
      nb_done = 0;
      chk("busy", busy, m_busy);
      chk("done", done, m_done_due);
      if (done) m_done_cnt++;
      exp_rdy = m_busy && (m_acc - 4 * m_freed < 8) && (m_acc < 4 * m_n);
      chk("s_ready", bus.s_ready, exp_rdy);
      if (bus.fml_stb) begin
        ea = m_base + 26'(16 * m_burst);
        chk("stb_we_sel", {bus.fml_we, bus.fml_sel}, 5'h1F);
        chk("stb_adr", bus.fml_adr, ea);
        chk("stb_allowed", (m_acc >= 4 * (m_burst + 1)) && (m_beat == 0) && m_busy, 1);
        if (!m_stb_prev) m_stb_rise_cyc = cyc;
      end else begin
        chk("we_idle", bus.fml_we, 0);
      end
      if (bus.fml_stb && bus.fml_ack) begin
        idx = 4 * m_burst;
        chk("do_w0", bus.fml_do, (idx < m_words.size()) ? m_words[idx] : 32'hDEADBEEF);
        if (m_bursts_seen == 0) m_first_adr = bus.fml_adr;
        m_last_adr = bus.fml_adr;
        m_bursts_seen++;
        m_beat = 1;
      end else if (m_beat > 0) begin
        idx = 4 * m_burst + m_beat;
        chk("do_beat", bus.fml_do, (idx < m_words.size()) ? m_words[idx] : 32'hDEADBEEF);
        if (m_beat == 3) begin
          m_beat = 0;
          m_freed++;
          m_burst++;
          if (m_burst == m_n) begin nb_done = 1; nb_busy = 0; end
        end else begin
          m_beat++;
        end
      end else begin
        chk("do_idle", bus.fml_do, 0);
      end
      if (bus.s_valid && bus.s_ready) begin
        if (src_q.size() > 0) m_words.push_back(src_q.pop_front());
        m_acc++;
        m_hs_cyc = cyc;
        if (m_acc - 4 * m_freed > m_max_buf) m_max_buf = m_acc - 4 * m_freed;
      end
      if (start && !m_busy) begin
        if (nbursts == 16'd0) nb_done = 1;
        else begin
          nb_busy = 1;
          m_n = int'(nbursts);
          m_base = base_adr & 26'h3FFFFF0;
          m_acc = 0; m_freed = 0; m_burst = 0;
          m_words.delete();
        end
      end
      m_busy = nb_busy;
      m_done_due = nb_done;
      m_stb_prev = bus.fml_stb;
    end
  end

  task automatic pulse_start(input logic [25:0] b, input int n);
    @(posedge sys_clk); #1;
    start = 1'b1; base_adr = b; nbursts = 16'(n);
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic run_xfer(input vec_t v);
    int d0;
    int budget;
    ack_delay = v.ack_delay; ack_rand = v.ack_rand; valid_pct = v.valid_pct; spur = v.spur;
    src_q.delete();
    for (int i = 0; i < 4 * v.n; i++) src_q.push_back(v.fixed ? 32'hA0 + 32'(i) : $urandom);
    d0 = m_done_cnt;
    m_bursts_seen = 0;
    m_max_buf = 0;
    pulse_start(v.base, v.n);
    if (v.busy_start) begin
      repeat (3) @(posedge sys_clk);
      #1;
      chk("busy_before_2nd_start", busy, 1);
      start = 1'b1; base_adr = ~v.base; nbursts = 16'd7;
      @(posedge sys_clk); #1;
      start = 1'b0;
    end
    budget = 0;
    while (m_done_cnt == d0 && budget < 3000) begin
      @(negedge sys_clk); #1;
      budget++;
    end
    repeat (2) @(posedge sys_clk);
    #1;
    chk("done_once", m_done_cnt - d0, 1);
    chk("bursts", m_bursts_seen, v.n);
    chk("words", v.n == 0 ? 0 : m_acc, 4 * v.n);
    if (v.n > 0) begin
      chk("first_adr", m_first_adr, v.exp_first);
      chk("last_adr", m_last_adr, v.exp_last);
    end
    if (v.n == 1) chk("stb_latency", m_stb_rise_cyc - m_hs_cyc, 1);
    if (v.ack_delay >= 10) chk("bp_depth", m_max_buf, 8);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    vec_t v;
    int budget;
    int d0;
    tbl[0] = '{26'h0000123, 1,  0, 0, 100, 0, 1, 0, 26'h0000120, 26'h0000120};
    tbl[1] = '{26'h0000000, 3, 10, 0, 100, 0, 0, 0, 26'h0000000, 26'h0000020};
    tbl[2] = '{26'h3FFFFF0, 2,  1, 0, 100, 0, 0, 0, 26'h3FFFFF0, 26'h0000000};
    tbl[3] = '{26'h0000450, 0,  0, 0, 100, 0, 0, 0, 26'h0000000, 26'h0000000};
    tbl[4] = '{26'h1000040, 2,  6, 0, 100, 0, 0, 1, 26'h1000040, 26'h1000050};
    tbl[5] = '{26'h1234567, 5,  0, 1,  60, 1, 0, 0, 26'h1234560, 26'h12345A0};
    tbl[6] = '{26'h3FFFFE5, 4,  2, 1,  70, 1, 0, 0, 26'h3FFFFE0, 26'h0000010};

    sys_rst_n = 1'b0; start = 1'b0; base_adr = '0; nbursts = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_busy_done", {busy, done}, 0);
    sys_rst_n = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("idle_after_reset", {busy, bus.fml_stb, bus.s_ready}, 0);

    for (int i = 0; i < 7; i++) run_xfer(tbl[i]);

    // reset during beat 1 of a burst
    ack_delay = 2; ack_rand = 0; spur = 0; valid_pct = 100;
    src_q.delete();
    for (int i = 0; i < 8; i++) src_q.push_back($urandom);
    pulse_start(26'h0ABCDE0, 2);
    budget = 0;
    while (m_beat != 1 && budget < 500) begin
      @(negedge sys_clk); #1;
      budget++;
    end
    chk("reach_beat1", m_beat, 1);
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b0;
    src_q.delete();
    d0 = m_done_cnt;
    #1;
    chk("rst_now_busy", busy, 0);
    chk("rst_now_stb_ready", {bus.fml_stb, bus.s_ready}, 0);
    chk("rst_now_do", bus.fml_do, 0);
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
    chk("no_done_after_abort", m_done_cnt - d0, 0);
    chk("stays_idle", {busy, bus.fml_stb}, 0);
    v = '{26'h2000037, 1, 0, 0, 100, 0, 0, 0, 26'h2000030, 26'h2000030};
    run_xfer(v);

    for (int k = 0; k < 6; k++) begin
      v.base       = 26'($urandom);
      v.n          = int'($urandom_range(1, 5));
      v.ack_delay  = 0;
      v.ack_rand   = 1;
      v.valid_pct  = int'($urandom_range(50, 100));
      v.spur       = 1;
      v.fixed      = 0;
      v.busy_start = 0;
      v.exp_first  = v.base & 26'h3FFFFF0;
      v.exp_last   = v.exp_first + 26'(16 * (v.n - 1));
      run_xfer(v);
    end

    repeat (3) @(posedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fml_wrdma.md
FML_WRDMA -- requirements
Module: fml_wrdma

Interface
REQ-001 The module SHALL have parameter sdram_depth, default 26, giving the FML byte-address width (capacity 2^sdram_depth bytes).
REQ-002 The module SHALL have input sys_clk, 1 bit: the only clock; all logic on its rising edge.
REQ-003 The module SHALL have input sys_rst_n, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have input start, 1 bit: one-cycle request to begin a transfer.
REQ-005 The module SHALL have input base_adr, sdram_depth bits: destination byte address; bits [3:0] are ignored and treated as 0.
REQ-006 The module SHALL have input nbursts, 16 bits: number of 16-byte bursts to write.
REQ-007 The module SHALL have output busy, 1 bit: transfer in progress.
REQ-008 The module SHALL have output done, 1 bit: one-cycle completion pulse.
REQ-009 The module SHALL have inputs s_valid (1 bit) and s_data (32 bits), and output s_ready (1 bit): the source word stream; a word transfers when s_valid and s_ready are both high.
REQ-010 The module SHALL have outputs fml_adr (sdram_depth bits), fml_stb, fml_we (1 bit each), fml_sel (4 bits) and fml_do (32 bits), and input fml_ack (1 bit): the FML 4x32 initiator port.

Function
REQ-011 The module SHALL store words in a ping-pong buffer of two halves, each holding 4 words (one burst); the fill side and the drain side operate concurrently.
REQ-012 start SHALL be accepted only while busy=0; while busy=1, start SHALL be ignored.
REQ-013 On an accepted start with nbursts>0, the module SHALL latch base_adr (with [3:0] forced to 0) and nbursts, and set busy=1 on the next cycle.
REQ-014 On an accepted start with nbursts=0, done SHALL pulse on the next cycle, busy SHALL stay 0, and no FML or stream activity SHALL occur.
REQ-015 s_ready SHALL be high only when busy=1, the half currently being filled is not full, and fewer than 4*nbursts words have been accepted.
REQ-016 Accepted words SHALL fill the current half in order (word index 0..3); on the 4th word that half SHALL be marked full and filling SHALL switch to the other half.
REQ-017 The drain FSM SHALL have exactly three states: D_IDLE, D_REQ and D_BEAT.
REQ-018 From D_IDLE, when the next drain half is full, the drain FSM SHALL go to D_REQ and assert fml_stb on the cycle after the half becomes full (latency 1 cycle from the 4th accepted word).
REQ-019 In D_REQ, fml_stb=1, fml_we=1, fml_sel=4'hF and fml_adr=current burst address SHALL be held stable until fml_ack=1.
REQ-020 In the fml_ack cycle, fml_do SHALL carry word 0; in the following 3 cycles (D_BEAT), fml_do SHALL carry words 1, 2 and 3; fml_stb SHALL be 0 from the cycle after ack.
REQ-021 After the beat-3 cycle, the drained half SHALL be marked empty and the burst address SHALL advance by 16, wrapping modulo 2^sdram_depth.
REQ-022 A new fml_stb SHALL be asserted no earlier than the cycle after beat 3.
REQ-023 If a half is filled and the other half is freed in the same cycle, both events SHALL take effect with no lost word or extra stall.
REQ-024 When fml_ack arrives in the same cycle fml_stb first rises, the module SHALL treat it as a valid acknowledgement.
REQ-025 fml_ack received while fml_stb=0 SHALL be ignored.
REQ-026 After beat 3 of burst nbursts, done SHALL pulse for one cycle on the next cycle, and busy SHALL fall in that same cycle.
REQ-027 When not in D_REQ, fml_stb SHALL be 0 and fml_we SHALL be 0; fml_do SHALL be 0 outside the ack and beat cycles.

Reset
REQ-028 While sys_rst_n=0, the following outputs SHALL be 0: busy, done, s_ready, fml_stb, fml_we, fml_sel, fml_adr and fml_do.
REQ-029 While sys_rst_n=0, the drain FSM SHALL be in D_IDLE, both buffer halves SHALL be empty, and all counters SHALL be 0.
REQ-030 Reset asserted mid-transfer, including mid-burst, SHALL abort immediately with no done pulse, and SHALL discard buffered data.
REQ-031 After sys_rst_n rises, the module SHALL require a new start before doing anything.

Verification
REQ-032 The bench SHALL cover a single burst: start with base_adr=0x0000123, nbursts=1, and stream 0xA0..0xA3 -> exactly one stb with fml_adr=0x0000120, fml_we=1 and fml_sel=F; fml_do carries A0,A1,A2,A3 on the ack cycle and the next 3 cycles; done follows one cycle after the last beat.
REQ-033 The bench SHALL cover back-pressure: nbursts=3, s_valid always high, and fml_ack delayed by 10 cycles per request -> s_ready drops after 8 words are buffered; addresses 0x0, 0x10 and 0x20 are written in order; exactly 12 words are transferred.
REQ-034 The bench SHALL cover wrap-around: sdram_depth=26, base_adr=0x3FFFFF0 and nbursts=2 -> burst addresses are 0x3FFFFF0 then 0x0000000.
REQ-035 The bench SHALL cover zero length and busy start: nbursts=0 -> done one cycle later with no stb; a start issued while busy=1 -> ignored, and the original transfer count is unchanged.
REQ-036 The bench SHALL cover reset mid-burst: sys_rst_n pulled low during beat 1 -> fml_stb, busy and s_ready are 0 immediately; no done; after release and a new start, the first burst uses the new base_adr.
